// File: rtl/dma_priority_arbiter.sv
// Channel arbiter/sequencer for the 4-channel DMA controller.
// Raises HRQ on an unmasked request, waits for HLDA, grants one channel (fixed or
// rotating priority) and holds the grant until EOP_n, a demand drop at xfer_done,
// or the CPU withdrawing HLDA.
// Optional feature: define DMA_ARB_DREQ_SYNC_EN to pass DREQ and EOP_n through a
// 2-flop synchronizer (adds 2 cycles of input latency).
module dma_priority_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] mask,
  input  logic [7:0]        cmd_reg,
  input  logic              EOP_n,
  input  logic              xfer_done,
  input  logic              HLDA,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_ch
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGrant,
    StRelease
  } state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] ack_q;
  logic [CH_W-1:0]   ptr_q;

  logic [NUM_CH-1:0] dreq_s;
  logic              eop_n_s;
  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   win_ch;
  logic [CH_W-1:0]   rot_idx;
  logic              found;
  logic [NUM_CH-1:0] win_onehot;
  logic              grant_exit;

`ifdef DMA_ARB_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreq_meta_q, dreq_sync_q;
  logic              eop_meta_q, eop_sync_q;

  // Two-flop synchronizers; reset to the inactive level so no spurious request appears
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      dreq_meta_q <= {NUM_CH{~cmd_reg[6]}};
      dreq_sync_q <= {NUM_CH{~cmd_reg[6]}};
      eop_meta_q  <= 1'b1;
      eop_sync_q  <= 1'b1;
    end else begin
      dreq_meta_q <= DREQ;
      dreq_sync_q <= dreq_meta_q;
      eop_meta_q  <= EOP_n;
      eop_sync_q  <= eop_meta_q;
    end
  end

  assign dreq_s  = dreq_sync_q;
  assign eop_n_s = eop_sync_q;
`else
  assign dreq_s  = DREQ;
  assign eop_n_s = EOP_n;
`endif

  // Effective request after polarity correction and masking
  always_comb begin
    req = (cmd_reg[6] ? dreq_s : ~dreq_s) & ~mask;
  end

  // Winner selection: fixed (lowest index) or rotating (search from ptr+1, wrapping)
  always_comb begin
    win_ch  = '0;
    rot_idx = '0;
    found   = 1'b0;
    if (cmd_reg[4]) begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        // Index wraps naturally because NUM_CH is a power of two
        rot_idx = ptr_q + CH_W'(k);
        if (!found && req[rot_idx]) begin
          win_ch = rot_idx;
          found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!found && req[CH_W'(i)]) begin
          win_ch = CH_W'(i);
          found  = 1'b1;
        end
      end
    end
    win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << win_ch;
  end

  // EOP and a completed transfer in the same cycle collapse into a single exit
  always_comb begin
    grant_exit = !eop_n_s || (xfer_done && !req[grant_ch]);
  end

  // Arbitration FSM with registered HRQ, ack and grant outputs
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      HRQ         <= 1'b0;
      ack_q       <= '0;
      grant_valid <= 1'b0;
      grant_ch    <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cmd_reg[2] && |req) begin
            HRQ     <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (HLDA) begin
            if (|req) begin
              ack_q       <= win_onehot;
              grant_ch    <= win_ch;
              grant_valid <= 1'b1;
              state_q     <= StGrant;
            end else begin
              // Request withdrawn before the bus was handed over
              HRQ     <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StGrant: begin
          if (!HLDA) begin
            // CPU reclaimed the bus: abort without advancing the rotation
            ack_q       <= '0;
            grant_valid <= 1'b0;
            HRQ         <= 1'b0;
            state_q     <= StIdle;
          end else if (grant_exit) begin
            ack_q       <= '0;
            grant_valid <= 1'b0;
            HRQ         <= 1'b0;
            if (cmd_reg[4]) begin
              ptr_q <= grant_ch;
            end
            state_q     <= StRelease;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign DACK = cmd_reg[7] ? ack_q : ~ack_q;

endmodule
